z80_cycle_gen: RTL and testbench
================================

# z80_cycle_gen

Z80 bus-cycle initiator: turns a single-word request interface into Z80-timed bus cycles, driving A, D, MREQ, IORQ, RD, WR, M1 and RFSH exactly as a Z80 would. It is the other end of the board's strobe decoder, which qualifies RD/WR with MREQ/IORQ/RFSH into MEMR/MEMW/IOR/IOW and the DRAM strobes. It serves as the bus master for the cartridge dumper/tester and as a stimulus source for the decoder. Resolution is half a T-state: one `clk` cycle is one T-state half, written `a` for the high half and `b` for the low half.

## Interface
- `MEM_TW`, default 0: extra wait states forced into every memory cycle (0–7), on top of any inserted by `wait_n`.
- `clk`  in  1: half-T-state clock, at twice the emulated Z80 clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  1: start a cycle. Sampled only while `ready`=1.
- `op`  in  2: cycle type. 00 = mem read, 01 = mem write, 10 = io read, 11 = io write. Captured with `req`.
- `m1`  in  1: with op=00, marks the cycle as an opcode fetch. Ignored for other ops.
- `addr`  in  16: bus address, captured with `req`.
- `wdata`  in  8: write data, captured with `req`.
- `ready`  out  1: idle and able to accept `req`.
- `done`  out  1: one-cycle pulse when a cycle completes.
- `rdata`  out  8: read data. Holds its value until the next read sample.
- `a`  out  16: address bus.
- `d_out`  out  8: data out. `d_oe`  out  1: data bus output enable.
- `d_in`  in  8: data in.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n`  out  1 each: active-low Z80 strobes.
- `wait_n`  in  1: active-low wait request, synchronous to `clk`.

## Operation
- States: IDLE, T1a, T1b, T2a, T2b, TWa, TWb, T3a, T3b, T4a, T4b.
- All outputs are registered and change only on the rising edge of `clk`. "Low during X..Y" means the output is low for every cycle spent in states X through Y inclusive.
- **Accept.** In IDLE with `req`=1, capture op/m1/addr/wdata and go to T1a. `req` while busy is ignored.
- **`a`.** Driven with `addr` from T1a until the end of the cycle. `a` holds its last value in IDLE.
- **Mem read.**
  - `mreq_n` and `rd_n` are low during T1b..T3a.
  - `d_in` is sampled into `rdata` at the end of T3a.
- **Opcode fetch (m1=1).**
  - `m1_n` is low during T1a..T2b or the last TWb.
  - `mreq_n` and `rd_n` are low during T1b..T2b or the last TWb.
  - `rdata` is sampled at the end of the last T2b/TWb.
  - The cycle then runs the refresh phases T3a..T4b (see Configuration).
- **Mem write.**
  - `d_oe`=1 during T1b..T3b, with `d_out`=wdata.
  - `mreq_n` is low during T1b..T3a.
  - `wr_n` is low during T2b..T3a.
- **IO read/write.**
  - `iorq_n` and `rd_n`/`wr_n` are low during T2a..T3a.
  - Exactly one TW is always inserted.
  - For writes, `d_oe`=1 during T1b..T3b.
  - For reads, `rdata` is sampled at the end of T3a.
- **Wait states.**
  - Memory cycles: `wait_n` is sampled at the end of T2a. After `MEM_TW` forced TW pairs, `wait_n` is sampled again at the end of each TWa.
  - IO cycles: `wait_n` is sampled at the end of the mandatory TWa.
  - `wait_n`=0 at a sample inserts another TWa/TWb pair. There is no timeout.
- **Completion.** After the final state (T3b, or T4b for M1), the block returns to IDLE. `done` is 1 and `ready` is 1 in that first IDLE cycle.
- **Back-to-back.** `req` held high during the `done` cycle starts T1a on the next cycle, so there are no idle cycles between bus cycles.
- **Reset.**
  - All strobes = 1, `d_oe`=0, `a`=0, `d_out`=0, `rdata`=0, R=0, `ready`=1, `done`=0, state=IDLE.
  - Reset mid-cycle releases all strobes immediately and never produces `done`.

## Timing
- Request is sampled at edge k. T1a occupies cycle k+1.
- Cycle lengths, counted in `clk` cycles from T1a with `wait_n`=1 and `MEM_TW`=0:
  - Mem read or write: 6 cycles.
  - IO: 8 cycles.
  - Opcode fetch: 8 cycles.
- `done` occurs at cycle k+1+length.
- Each wait pair adds 2 cycles.
- Strobes never glitch: each strobe has at most one falling edge and one rising edge per bus cycle, except in M1 cycles, where `mreq_n` gets a second pulse for refresh.

## Configuration
- `MITEC2_REFRESH_EN` defined (M1 refresh phases enabled):
  - `rfsh_n` is low during T3a..T4b.
  - `a[6:0]`=R and `a[15:7]`=0 during T3a..T4b.
  - `mreq_n` is low during T3b..T4a. `rd_n` stays high.
  - R is a 7-bit counter that increments after T4b and wraps from 127 to 0.
- `MITEC2_REFRESH_EN` undefined (refresh phases removed):
  - An M1 cycle ends after T2b or the last TWb. It is 4 cycles long with `wait_n`=1.
  - `rfsh_n` is held at 1 and R is absent.

## Test plan
- **Mem read.** Mem read at addr=0xC123 with `d_in`=0x5A and `wait_n`=1 → `mreq_n`/`rd_n` low for 4 cycles, `rdata`=0x5A, `done` 7 cycles after `req`.
- **Mem write with wait.** Mem write of wdata=0xA5 at 0x8000 with `wait_n`=0 at the T2a sample only → `wr_n` low for 4 cycles, `d_out`=0xA5 while `d_oe`=1, total length 8 cycles.
- **IO read.** IO read at 0x0080 with `d_in`=0x3C → `iorq_n` low during T2a..T3a (5 cycles), `rdata`=0x3C, `mreq_n` never low.
- **Refresh wrap (REFRESH_EN).** 129 consecutive M1 fetches → `a[6:0]` during refresh is 0,1,…,127,0. `rfsh_n` is low for 4 cycles per fetch. Back-to-back cycles have no idle gap.
- **Reset mid-cycle.** Assert `rst` during T2a of a mem write → `wr_n`/`mreq_n` high and `d_oe`=0 asynchronously, no `done`, `ready`=1 after release.
- **Forced waits.** `MEM_TW`=2 with `wait_n`=1 → a mem read lasts 10 cycles.

Source files
------------

// File: rtl/z80_cycle_gen_if.sv
// Request and Z80 bus bundle for z80_cycle_gen. The master side is the cycle
// generator; the slave side is whatever drives requests and answers the bus.
interface z80_cycle_gen_if;
  logic        req;
  logic [1:0]  op;
  logic        m1;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        done;
  logic [7:0]  rdata;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic        wait_n;

  modport master (
    input  req, op, m1, addr, wdata, d_in, wait_n,
    output ready, done, rdata, a, d_out, d_oe,
           mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n
  );

  modport slave (
    output req, op, m1, addr, wdata, d_in, wait_n,
    input  ready, done, rdata, a, d_out, d_oe,
           mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n
  );
endinterface

// File: rtl/z80_cycle_gen.sv
// Z80 bus-cycle initiator at half-T-state resolution (one clk = one T half).
// Define MITEC2_REFRESH_EN to add the T3/T4 refresh phases to opcode fetches.
module z80_cycle_gen #(
  parameter int MEM_TW = 0
) (
  input  logic       clk,
  input  logic       rst,
  z80_cycle_gen_if.master bus
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T1A  = 4'd1;
  localparam logic [3:0] S_T1B  = 4'd2;
  localparam logic [3:0] S_T2A  = 4'd3;
  localparam logic [3:0] S_T2B  = 4'd4;
  localparam logic [3:0] S_TWA  = 4'd5;
  localparam logic [3:0] S_TWB  = 4'd6;
  localparam logic [3:0] S_T3A  = 4'd7;
  localparam logic [3:0] S_T3B  = 4'd8;
  localparam logic [3:0] S_T4A  = 4'd9;
  localparam logic [3:0] S_T4B  = 4'd10;

  localparam logic [2:0] TW_INIT = 3'(MEM_TW);

  logic [3:0]  state, ns, after_t2;
  logic [1:0]  op_q;
  logic        m1_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [2:0]  fcnt, fcnt_nxt;
  logic        ins_wait, wait_dec;
  logic        accept, fetch_q, samp;
  logic [1:0]  c_op;
  logic        c_fetch;
  logic [15:0] c_addr, a_d;
  logic [7:0]  c_wdata;
  logic        mreq_d, iorq_d, rd_d, wr_d, m1_d, rfsh_d, oe_d;
`ifdef MITEC2_REFRESH_EN
  logic [6:0]  r;
`endif

  assign accept  = (state == S_IDLE) && bus.req;
  assign fetch_q = (op_q == 2'b00) && m1_q;

  // Outputs are registered from the next state, so the "current" request
  // fields must come straight from the inputs on the accepting edge.
  assign c_op    = accept ? bus.op    : op_q;
  assign c_fetch = (c_op == 2'b00) && (accept ? bus.m1 : m1_q);
  assign c_addr  = accept ? bus.addr  : addr_q;
  assign c_wdata = accept ? bus.wdata : wdata_q;

  always_comb begin
    after_t2 = S_T3A;
`ifdef MITEC2_REFRESH_EN
`else
    if (fetch_q) after_t2 = S_IDLE;
`endif
    ns = state;
    case (state)
      S_IDLE:       if (bus.req) ns = S_T1A;
      S_T1A:        ns = S_T1B;
      S_T1B:        ns = S_T2A;
      S_T2A:        ns = S_T2B;
      S_T2B, S_TWB: ns = ins_wait ? S_TWA : after_t2;
      S_TWA:        ns = S_TWB;
      S_T3A:        ns = S_T3B;
`ifdef MITEC2_REFRESH_EN
      S_T3B:        ns = fetch_q ? S_T4A : S_IDLE;
`else
      S_T3B:        ns = S_IDLE;
`endif
      S_T4A:        ns = S_T4B;
      S_T4B:        ns = S_IDLE;
      default:      ns = S_IDLE;
    endcase
  end

  // IO always takes one TW at T2a; memory burns forced pairs before honouring wait_n.
  always_comb begin
    wait_dec = !bus.wait_n;
    fcnt_nxt = fcnt;
    if (state == S_T2A && op_q[1]) begin
      wait_dec = 1'b1;
    end else if (fcnt != 3'd0) begin
      wait_dec = 1'b1;
      fcnt_nxt = fcnt - 3'd1;
    end
  end

  always_comb begin
    mreq_d = 1'b1;
    iorq_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    m1_d   = 1'b1;
    rfsh_d = 1'b1;
    oe_d   = 1'b0;
    a_d    = c_addr;
    if (!c_op[1]) begin
      if (c_fetch) begin
        m1_d   = !(ns inside {S_T1A, S_T1B, S_T2A, S_T2B, S_TWA, S_TWB});
        mreq_d = !(ns inside {S_T1B, S_T2A, S_T2B, S_TWA, S_TWB});
        rd_d   = mreq_d;
`ifdef MITEC2_REFRESH_EN
        rfsh_d = !(ns inside {S_T3A, S_T3B, S_T4A, S_T4B});
        if (ns inside {S_T3B, S_T4A}) mreq_d = 1'b0;
        if (!rfsh_d) a_d = {9'd0, r};
`endif
      end else begin
        mreq_d = !(ns inside {S_T1B, S_T2A, S_T2B, S_TWA, S_TWB, S_T3A});
        if (c_op[0]) begin
          wr_d = !(ns inside {S_T2B, S_TWA, S_TWB, S_T3A});
          oe_d = ns inside {S_T1B, S_T2A, S_T2B, S_TWA, S_TWB, S_T3A, S_T3B};
        end else begin
          rd_d = mreq_d;
        end
      end
    end else begin
      iorq_d = !(ns inside {S_T2A, S_T2B, S_TWA, S_TWB, S_T3A});
      if (c_op[0]) begin
        wr_d = iorq_d;
        oe_d = ns inside {S_T1B, S_T2A, S_T2B, S_TWA, S_TWB, S_T3A, S_T3B};
      end else begin
        rd_d = iorq_d;
      end
    end
  end

  always_comb begin
    if (fetch_q) samp = (state == S_T2B || state == S_TWB) && !ins_wait;
    else         samp = (state == S_T3A) && !op_q[0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= 2'b00;
      m1_q       <= 1'b0;
      fcnt       <= 3'd0;
      ins_wait   <= 1'b0;
      bus.ready  <= 1'b1;
      bus.done   <= 1'b0;
      bus.mreq_n <= 1'b1;
      bus.iorq_n <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.m1_n   <= 1'b1;
      bus.rfsh_n <= 1'b1;
      bus.d_oe   <= 1'b0;
      bus.a      <= 16'd0;
      bus.d_out  <= 8'd0;
      bus.rdata  <= 8'd0;
`ifdef MITEC2_REFRESH_EN
      r          <= 7'd0;
`endif
    end else begin
      state <= ns;
      if (accept) begin
        op_q <= bus.op;
        m1_q <= bus.m1;
        fcnt <= bus.op[1] ? 3'd0 : TW_INIT;
      end
      if (state == S_T2A || state == S_TWA) begin
        ins_wait <= wait_dec;
        fcnt     <= fcnt_nxt;
      end
      bus.ready  <= (ns == S_IDLE);
      bus.done   <= (ns == S_IDLE) && (state != S_IDLE);
      bus.mreq_n <= mreq_d;
      bus.iorq_n <= iorq_d;
      bus.rd_n   <= rd_d;
      bus.wr_n   <= wr_d;
      bus.m1_n   <= m1_d;
      bus.rfsh_n <= rfsh_d;
      bus.d_oe   <= oe_d;
      if (ns != S_IDLE) bus.a <= a_d;
      if (oe_d)         bus.d_out <= c_wdata;
      if (samp)         bus.rdata <= bus.d_in;
`ifdef MITEC2_REFRESH_EN
      if (state == S_T4B) r <= r + 7'd1;
`endif
    end
  end

endmodule

// File: tb/tb_z80_cycle_gen.sv
// Scoreboard bench for z80_cycle_gen: per-cycle strobe counts from a bus
// monitor are compared against a small model of each requested cycle.
module tb_z80_cycle_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z80_cycle_gen_if bus();
  z80_cycle_gen_if bus2();

  z80_cycle_gen dut (.clk(clk), .rst(rst), .bus(bus.master));
  z80_cycle_gen #(.MEM_TW(2)) dut_tw (.clk(clk), .rst(rst), .bus(bus2.master));

  typedef struct {
    int         len, mreq, iorq, rd, wr, m1l, rfsh, oe;
    logic       chk_rd;
    logic [7:0] rd_v;
    logic [7:0] wd;
    logic       chk_r;
    logic [6:0] rv;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   r_model = 0;
  int   idle_cnt = 0;
  int   c_len, c_mreq, c_iorq, c_rd, c_wr, c_m1, c_rfsh, c_oe;
  logic [7:0] last_dout;
  logic [6:0] ref_a;
  logic [8:0] ref_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic m1, input int w,
                                 input logic [7:0] din, input logic [7:0] wd);
    exp_t e;
    e = '{default: 0};
    e.wd = wd;
    if (op == 2'b00 && m1) begin
`ifdef MITEC2_REFRESH_EN
      e.len = 8 + 2*w; e.mreq = 5 + 2*w; e.rfsh = 4;
      e.chk_r = 1'b1;  e.rv = r_model[6:0];
`else
      e.len = 4 + 2*w; e.mreq = 3 + 2*w;
`endif
      e.m1l = 4 + 2*w; e.rd = 3 + 2*w;
      e.chk_rd = 1'b1; e.rd_v = din;
    end else begin
      case (op)
        2'b00: begin e.len = 6 + 2*w; e.mreq = 4 + 2*w; e.rd = 4 + 2*w;
                     e.chk_rd = 1'b1; e.rd_v = din; end
        2'b01: begin e.len = 6 + 2*w; e.mreq = 4 + 2*w; e.wr = 2 + 2*w; e.oe = 5 + 2*w; end
        2'b10: begin e.len = 8 + 2*w; e.iorq = 5 + 2*w; e.rd = 5 + 2*w;
                     e.chk_rd = 1'b1; e.rd_v = din; end
        default: begin e.len = 8 + 2*w; e.iorq = 5 + 2*w; e.wr = 5 + 2*w; e.oe = 7 + 2*w; end
      endcase
    end
    return e;
  endfunction

  task automatic clr_mon();
    c_len = 0; c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rfsh = 0; c_oe = 0;
    last_dout = 8'd0; ref_a = 7'd0; ref_hi = 9'd0;
  endtask

  // Bus monitor: accumulates strobe activity per cycle and scores it on done.
  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      if (rst) begin
        clr_mon();
      end else if (bus.done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("len",    32'(c_len),  32'(mon_e.len));
          check("mreq_lo", 32'(c_mreq), 32'(mon_e.mreq));
          check("iorq_lo", 32'(c_iorq), 32'(mon_e.iorq));
          check("rd_lo",  32'(c_rd),   32'(mon_e.rd));
          check("wr_lo",  32'(c_wr),   32'(mon_e.wr));
          check("m1_lo",  32'(c_m1),   32'(mon_e.m1l));
          check("rfsh_lo", 32'(c_rfsh), 32'(mon_e.rfsh));
          check("oe_cnt", 32'(c_oe),   32'(mon_e.oe));
          if (mon_e.chk_rd) check("rdata", 32'(bus.rdata), 32'(mon_e.rd_v));
          if (mon_e.oe != 0) check("d_out", 32'(last_dout), 32'(mon_e.wd));
          if (mon_e.chk_r) begin
            check("rfsh_a", 32'(ref_a), 32'(mon_e.rv));
            check("rfsh_ahi", 32'(ref_hi), 32'd0);
          end
        end
        clr_mon();
      end else if (!bus.ready) begin
        c_len++;
        if (!bus.mreq_n) c_mreq++;
        if (!bus.iorq_n) c_iorq++;
        if (!bus.rd_n)   c_rd++;
        if (!bus.wr_n)   c_wr++;
        if (!bus.m1_n)   c_m1++;
        if (bus.d_oe) begin c_oe++; last_dout = bus.d_out; end
        if (!bus.rfsh_n) begin
          c_rfsh++;
          ref_a  = bus.a[6:0];
          ref_hi = ref_hi | bus.a[15:7];
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic m1, input logic [15:0] ad,
                       input logic [7:0] wd, input logic [7:0] din, input int w,
                       input bit expect_done);
    int t = 0;
    while (!bus.ready && t < 200) begin @(negedge clk); t++; end
    check("accept_rdy", 32'(bus.ready), 32'd1);
    bus.op = op; bus.m1 = m1; bus.addr = ad; bus.wdata = wd; bus.d_in = din;
    bus.req = 1'b1;
    if (expect_done) begin
      sbq.push_back(model(op, m1, w, din, wd));
      if (op == 2'b00 && m1) r_model++;
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req = 0; bus.op = 0; bus.m1 = 0; bus.addr = 0; bus.wdata = 0; bus.d_in = 0; bus.wait_n = 1;
    bus2.req = 0; bus2.op = 0; bus2.m1 = 0; bus2.addr = 0; bus2.wdata = 0; bus2.d_in = 0; bus2.wait_n = 1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_strb",  32'({bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.m1_n, bus.rfsh_n}), 32'h3f);
    check("rst_a",     32'(bus.a),     32'd0);
    check("rst_doe",   32'(bus.d_oe),  32'd0);
    check("rst_dout",  32'(bus.d_out), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mem read, no waits: done 7 cycles after the accepting edge.
    issue(2'b00, 1'b0, 16'hC123, 8'h00, 8'h5A, 0, 1'b1);
    n = 0;
    while (!bus.done && n < 50) begin @(negedge clk); n++; end
    check("rd_lat", 32'(n), 32'd6);
    check("rd_a_hold", 32'(bus.a), 32'hC123);

    // Mem write with wait_n low only at the T2a sample.
    issue(2'b01, 1'b0, 16'h8000, 8'hA5, 8'h00, 1, 1'b1);
    @(negedge clk);
    @(negedge clk); bus.wait_n = 1'b0;
    @(negedge clk); bus.wait_n = 1'b1;
    wait_done("wr_done");

    // Mem read with wait_n low at T2a and the first TWa sample.
    issue(2'b00, 1'b0, 16'h0001, 8'h00, 8'hC3, 2, 1'b1);
    @(negedge clk);
    @(negedge clk); bus.wait_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.wait_n = 1'b1;
    wait_done("rdw_done");

    // IO read; m1 must be ignored for non-fetch ops.
    issue(2'b10, 1'b1, 16'h0080, 8'h00, 8'h3C, 0, 1'b1);
    wait_done("io_rd_done");

    // IO write with one wait on top of the mandatory TW.
    issue(2'b11, 1'b0, 16'h00FE, 8'h81, 8'h00, 1, 1'b1);
    repeat (4) @(negedge clk);
    bus.wait_n = 1'b0;
    @(negedge clk); bus.wait_n = 1'b1;
    wait_done("io_wr_done");

    // Reset in T2a of a mem write: strobes release at once, no done.
    issue(2'b01, 1'b0, 16'h1234, 8'h77, 8'h00, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_mreq", 32'(bus.mreq_n), 32'd1);
    check("mid_wr",   32'(bus.wr_n),   32'd1);
    check("mid_doe",  32'(bus.d_oe),   32'd0);
    check("mid_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    r_model = 0;
    repeat (10) @(negedge clk);
    check("post_rst_ready", 32'(bus.ready), 32'd1);

    // 129 back-to-back opcode fetches: refresh address wraps, no idle gaps.
    for (int i = 0; i < 129; i++) begin
      issue(2'b00, 1'b1, 16'h4000 + 16'(i), 8'h00, 8'(i) ^ 8'h3C, 0, 1'b1);
      if (i == 0) idle_cnt = 0;
    end
    wait_done("m1_done");
    check("b2b_gap", 32'(idle_cnt), 32'd0);

    // Forced waits on the MEM_TW=2 instance.
    @(negedge clk);
    bus2.op = 2'b00; bus2.m1 = 1'b0; bus2.addr = 16'h2222; bus2.d_in = 8'hE7;
    bus2.req = 1'b1;
    @(negedge clk);
    bus2.req = 1'b0;
    n = 0;
    for (int t = 0; t < 60 && !bus2.done; t++) begin
      if (!bus2.ready) n++;
      @(negedge clk);
    end
    check("tw2_done",  32'(bus2.done),  32'd1);
    check("tw2_len",   32'(n),          32'd10);
    check("tw2_rdata", 32'(bus2.rdata), 32'hE7);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
